decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 64, SHALL set the register and datapath width.
REQ-002 Parameter NUM_REGS, default 15, SHALL set the number of implemented registers: IDs 0..NUM_REGS-1 are valid, 4'hF means "none".
REQ-003 clk  input  1  SHALL be the rising-edge clock for the register file and the E pipeline register.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 D_icode, D_ifun, D_rA, D_rB  input  4 each  SHALL carry the fetched instruction fields.
REQ-006 D_valC, D_valP  input  DATA_W  SHALL carry the constant word and the next PC.
REQ-007 D_stat  input  3  SHALL carry the fetch status (AOK=1, HLT=2, ADR=3, INS=4).
REQ-008 E_stall, E_bubble  input  1 each  SHALL be the hazard-unit controls for the E register.
REQ-009 e_dstE  input  4 and e_valE  input  DATA_W  SHALL carry the execute-stage result.
REQ-010 M_dstE, m_dstM  input  4 and M_valE, m_valM  input  DATA_W  SHALL carry the memory-stage results.
REQ-011 W_dstE, W_dstM  input  4 and W_valE, W_valM  input  DATA_W  SHALL carry the writeback results and SHALL also act as the register-file write ports.
REQ-012 d_srcA, d_srcB  output  4  SHALL be combinational source IDs for the hazard unit.
REQ-013 E_stat (3), E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB (4 each) and E_valC, E_valA, E_valB (DATA_W)  outputs  SHALL be registered.
REQ-014 load_use  output  1  SHALL be a combinational load/use hazard flag.

Function
REQ-015 srcA SHALL be: icode 2, 4, 6 or 10 -> D_rA; icode 9 or 11 -> 4 (RSP); otherwise F.
REQ-016 srcB SHALL be: icode 4, 5 or 6 -> D_rB; icode 8, 9, 10 or 11 -> 4; otherwise F.
REQ-017 dstE SHALL be: icode 2, 3 or 6 -> D_rB; icode 8, 9, 10 or 11 -> 4; otherwise F.
REQ-018 dstM SHALL be: icode 5 or 11 -> D_rA; otherwise F; icodes 0, 1, 7 and 12-15 SHALL yield F for all four selectors.
REQ-019 ID F, or any ID >= NUM_REGS, SHALL read 0, SHALL never match a forwarding source and SHALL make a write a no-op.
REQ-020 Register-file writes SHALL occur on the rising edge: reg[W_dstE] <= W_valE and reg[W_dstM] <= W_valM; when both IDs are equal and valid, W_valM SHALL win.
REQ-021 Register-file reads SHALL be combinational.
REQ-022 valA SHALL be selected in this priority order:
  - icode 7 or 8 -> D_valP
  - srcA==e_dstE -> e_valE
  - srcA==m_dstM -> m_valM
  - srcA==M_dstE -> M_valE
  - srcA==W_dstM -> W_valM
  - srcA==W_dstE -> W_valE
  - otherwise reg[srcA]
REQ-023 valB SHALL use the same priority on srcB, without the D_valP term.
REQ-024 E register update per rising edge SHALL be: E_bubble=1 -> load bubble (E_bubble wins over E_stall); else E_stall=1 -> hold; else load the decoded values.
REQ-025 A bubble SHALL be: stat=1, icode=1, ifun=0, dstE/dstM/srcA/srcB=F, valC/valA/valB=0.
REQ-026 load_use SHALL be 1 iff E_icode is 5 or 11, E_dstM!=F, and E_dstM equals d_srcA or d_srcB; the block SHALL take no internal action on it.
REQ-027 D-to-E latency SHALL be exactly one clock; register-file write-to-read SHALL be visible via W forwarding in the same cycle and via the array from the next cycle.

Reset
REQ-028 reset=1 SHALL immediately, without waiting for clk, clear all NUM_REGS registers to 0 and load a bubble into E.
REQ-029 While reset=1, writes SHALL be ignored; the first rising edge after deassertion SHALL operate normally.

Verification
REQ-030 Reset mid-run with regs nonzero -> immediately E_icode=1, E_dstE=F, E_stat=1; a subsequent read of every register returns 0.
REQ-031 W_dstE=3, W_valE=0x11 and W_dstM=3, W_valM=0x22 on one edge, then D_icode=2, D_rA=3 -> E_valA=0x22.
REQ-032 D_icode=6, D_rA=2 with e_dstE=2 (0xA), m_dstM=2 (0xB) and W_dstE=2 (0xC) all active -> E_valA=0xA; remove e_dstE -> E_valA=0xB.
REQ-033 D_icode=8, D_valP=0x40, e_dstE=F -> E_valA=0x40, E_srcB=4, E_dstE=4, E_dstM=F.
REQ-034 E_icode=5, E_dstM=6 and D_icode=6, D_rB=6 -> load_use=1; with E_stall=1 and E_bubble=1 together -> next E_icode=1.
REQ-035 NUM_REGS=8, W_dstE=10, W_valE=0x5 written, then read of ID 10 -> value 0, with no forwarding match on ID 10.

Source files
------------

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Decode stage of a five-stage Y86-64 style pipeline. It holds the register
//   file, chooses source/destination register IDs from the fetched
//   instruction, forwards in-flight results into valA/valB, and owns the
//   E pipeline register that feeds the execute stage.
//
// Parameters
//   DATA_W    datapath / register width
//   NUM_REGS  number of implemented registers (IDs 0..NUM_REGS-1, max 15);
//             ID 4'hF means "no register"
//
// Ports
//   i_clk                 rising-edge clock (register file and E register)
//   i_reset               asynchronous active-high reset
//   i_D_*                 fetched instruction fields, constant, next PC, status
//   i_E_stall/i_E_bubble  hazard-unit controls for the E register
//   i_e_dstE/i_e_valE     execute-stage result
//   i_M_dstE/i_M_valE     memory-stage ALU result
//   i_m_dstM/i_m_valM     memory-stage load result
//   i_W_*                 writeback results, also the register-file write ports
//   o_d_srcA/o_d_srcB     combinational source IDs for the hazard unit
//   o_E_*                 registered E pipeline register contents
//   o_load_use            combinational load/use hazard flag
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [3:0]        i_D_icode,
    input  logic [3:0]        i_D_ifun,
    input  logic [3:0]        i_D_rA,
    input  logic [3:0]        i_D_rB,
    input  logic [DATA_W-1:0] i_D_valC,
    input  logic [DATA_W-1:0] i_D_valP,
    input  logic [2:0]        i_D_stat,
    input  logic              i_E_stall,
    input  logic              i_E_bubble,
    input  logic [3:0]        i_e_dstE,
    input  logic [DATA_W-1:0] i_e_valE,
    input  logic [3:0]        i_M_dstE,
    input  logic [3:0]        i_m_dstM,
    input  logic [DATA_W-1:0] i_M_valE,
    input  logic [DATA_W-1:0] i_m_valM,
    input  logic [3:0]        i_W_dstE,
    input  logic [3:0]        i_W_dstM,
    input  logic [DATA_W-1:0] i_W_valE,
    input  logic [DATA_W-1:0] i_W_valM,
    output logic [3:0]        o_d_srcA,
    output logic [3:0]        o_d_srcB,
    output logic [2:0]        o_E_stat,
    output logic [3:0]        o_E_icode,
    output logic [3:0]        o_E_ifun,
    output logic [3:0]        o_E_dstE,
    output logic [3:0]        o_E_dstM,
    output logic [3:0]        o_E_srcA,
    output logic [3:0]        o_E_srcB,
    output logic [DATA_W-1:0] o_E_valC,
    output logic [DATA_W-1:0] o_E_valA,
    output logic [DATA_W-1:0] o_E_valB,
    output logic              o_load_use
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] I_RRMOVQ = 4'd2;
    localparam logic [3:0] I_IRMOVQ = 4'd3;
    localparam logic [3:0] I_RMMOVQ = 4'd4;
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_OPQ    = 4'd6;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSHQ  = 4'd10;
    localparam logic [3:0] I_POPQ   = 4'd11;

    localparam logic [2:0] STAT_AOK = 3'd1;

    // An ID names a real register only if it is not "none" and is below
    // NUM_REGS; anything else reads 0, never forwards and never writes.
    function automatic logic id_valid(input logic [3:0] id);
        return (id != RNONE) && (int'(id) < NUM_REGS);
    endfunction

    // -----------------------------------------------------------------------
    // Register ID selection
    // -----------------------------------------------------------------------
    logic [3:0] w_srcA;
    logic [3:0] w_srcB;
    logic [3:0] w_dstE;
    logic [3:0] w_dstM;

    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (i_D_icode)
            I_RRMOVQ: begin
                w_srcA = i_D_rA;
                w_dstE = i_D_rB;
            end
            I_IRMOVQ: begin
                w_dstE = i_D_rB;
            end
            I_RMMOVQ: begin
                w_srcA = i_D_rA;
                w_srcB = i_D_rB;
            end
            I_MRMOVQ: begin
                w_srcB = i_D_rB;
                w_dstM = i_D_rA;
            end
            I_OPQ: begin
                w_srcA = i_D_rA;
                w_srcB = i_D_rB;
                w_dstE = i_D_rB;
            end
            I_CALL: begin
                w_srcB = RSP;
                w_dstE = RSP;
            end
            I_RET: begin
                w_srcA = RSP;
                w_srcB = RSP;
                w_dstE = RSP;
            end
            I_PUSHQ: begin
                w_srcA = i_D_rA;
                w_srcB = RSP;
                w_dstE = RSP;
            end
            I_POPQ: begin
                w_srcA = RSP;
                w_srcB = RSP;
                w_dstE = RSP;
                w_dstM = i_D_rA;
            end
            default: begin
                // halt, nop, jXX and undefined codes touch no registers
            end
        endcase
    end

    assign o_d_srcA = w_srcA;
    assign o_d_srcB = w_srcB;

    // -----------------------------------------------------------------------
    // Register file
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_we_e;
    logic [NUM_REGS-1:0] w_we_m;
    logic                w_wr_e_ok;
    logic                w_wr_m_ok;

    assign w_wr_e_ok = id_valid(i_W_dstE);
    assign w_wr_m_ok = id_valid(i_W_dstM);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_we
            assign w_we_e[gi] = w_wr_e_ok && (i_W_dstE == 4'(gi));
            assign w_we_m[gi] = w_wr_m_ok && (i_W_dstM == 4'(gi));
        end
    endgenerate

    // The M port is checked first so a load result beats an ALU result
    // aimed at the same register on the same edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_we_m[i]) begin
                    r_regs[i] <= i_W_valM;
                end else if (w_we_e[i]) begin
                    r_regs[i] <= i_W_valE;
                end
            end
        end
    end

    // Combinational read ports; an ID outside the implemented range matches
    // no entry and therefore reads as zero.
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;

    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_srcA == 4'(i)) begin
                w_rd_a = r_regs[i];
            end
            if (w_srcB == 4'(i)) begin
                w_rd_b = r_regs[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Forwarding: youngest in-flight result wins
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] w_valA;
    logic [DATA_W-1:0] w_valB;
    logic              w_srcA_ok;
    logic              w_srcB_ok;

    assign w_srcA_ok = id_valid(w_srcA);
    assign w_srcB_ok = id_valid(w_srcB);

    always_comb begin
        w_valA = w_rd_a;
        // call and jXX carry the next PC down the valA lane
        if (i_D_icode == I_CALL || i_D_icode == I_JXX) begin
            w_valA = i_D_valP;
        end else if (w_srcA_ok) begin
            if (w_srcA == i_e_dstE) begin
                w_valA = i_e_valE;
            end else if (w_srcA == i_m_dstM) begin
                w_valA = i_m_valM;
            end else if (w_srcA == i_M_dstE) begin
                w_valA = i_M_valE;
            end else if (w_srcA == i_W_dstM) begin
                w_valA = i_W_valM;
            end else if (w_srcA == i_W_dstE) begin
                w_valA = i_W_valE;
            end
        end
    end

    always_comb begin
        w_valB = w_rd_b;
        if (w_srcB_ok) begin
            if (w_srcB == i_e_dstE) begin
                w_valB = i_e_valE;
            end else if (w_srcB == i_m_dstM) begin
                w_valB = i_m_valM;
            end else if (w_srcB == i_M_dstE) begin
                w_valB = i_M_valE;
            end else if (w_srcB == i_W_dstM) begin
                w_valB = i_W_valM;
            end else if (w_srcB == i_W_dstE) begin
                w_valB = i_W_valE;
            end
        end
    end

    // -----------------------------------------------------------------------
    // E pipeline register; bubble takes precedence over stall
    // -----------------------------------------------------------------------
    logic [2:0]        r_E_stat;
    logic [3:0]        r_E_icode;
    logic [3:0]        r_E_ifun;
    logic [3:0]        r_E_dstE;
    logic [3:0]        r_E_dstM;
    logic [3:0]        r_E_srcA;
    logic [3:0]        r_E_srcB;
    logic [DATA_W-1:0] r_E_valC;
    logic [DATA_W-1:0] r_E_valA;
    logic [DATA_W-1:0] r_E_valB;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset || i_E_bubble) begin
            r_E_stat  <= STAT_AOK;
            r_E_icode <= I_NOP;
            r_E_ifun  <= 4'd0;
            r_E_dstE  <= RNONE;
            r_E_dstM  <= RNONE;
            r_E_srcA  <= RNONE;
            r_E_srcB  <= RNONE;
            r_E_valC  <= '0;
            r_E_valA  <= '0;
            r_E_valB  <= '0;
        end else if (!i_E_stall) begin
            r_E_stat  <= i_D_stat;
            r_E_icode <= i_D_icode;
            r_E_ifun  <= i_D_ifun;
            r_E_dstE  <= w_dstE;
            r_E_dstM  <= w_dstM;
            r_E_srcA  <= w_srcA;
            r_E_srcB  <= w_srcB;
            r_E_valC  <= i_D_valC;
            r_E_valA  <= w_valA;
            r_E_valB  <= w_valB;
        end
    end

    assign o_E_stat  = r_E_stat;
    assign o_E_icode = r_E_icode;
    assign o_E_ifun  = r_E_ifun;
    assign o_E_dstE  = r_E_dstE;
    assign o_E_dstM  = r_E_dstM;
    assign o_E_srcA  = r_E_srcA;
    assign o_E_srcB  = r_E_srcB;
    assign o_E_valC  = r_E_valC;
    assign o_E_valA  = r_E_valA;
    assign o_E_valB  = r_E_valB;

    // -----------------------------------------------------------------------
    // Load/use hazard: a load in E whose destination is needed by the
    // instruction now in decode. Reported only; the hazard unit reacts.
    // -----------------------------------------------------------------------
    assign o_load_use = ((r_E_icode == I_MRMOVQ) || (r_E_icode == I_POPQ)) &&
                        (r_E_dstM != RNONE) &&
                        ((r_E_dstM == w_srcA) || (r_E_dstM == w_srcB));

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    localparam int W = 64;
    localparam logic [3:0] F = 4'hF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus
    logic [3:0]   D_icode, D_ifun, D_rA, D_rB;
    logic [W-1:0] D_valC, D_valP;
    logic [2:0]   D_stat;
    logic         E_stall, E_bubble;
    logic [3:0]   e_dstE, M_dstE, m_dstM, W_dstE, W_dstM;
    logic [W-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;

    // main DUT outputs
    logic [3:0]   d_srcA, d_srcB;
    logic [2:0]   E_stat;
    logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [W-1:0] E_valC, E_valA, E_valB;
    logic         load_use;

    // NUM_REGS=8 DUT outputs
    logic [3:0]   d8_srcA, d8_srcB;
    logic [2:0]   E8_stat;
    logic [3:0]   E8_icode, E8_ifun, E8_dstE, E8_dstM, E8_srcA, E8_srcB;
    logic [W-1:0] E8_valC, E8_valA, E8_valB;
    logic         load_use8;

    decode_stage #(.DATA_W(W), .NUM_REGS(15)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_D_icode(D_icode), .i_D_ifun(D_ifun), .i_D_rA(D_rA), .i_D_rB(D_rB),
        .i_D_valC(D_valC), .i_D_valP(D_valP), .i_D_stat(D_stat),
        .i_E_stall(E_stall), .i_E_bubble(E_bubble),
        .i_e_dstE(e_dstE), .i_e_valE(e_valE),
        .i_M_dstE(M_dstE), .i_m_dstM(m_dstM), .i_M_valE(M_valE), .i_m_valM(m_valM),
        .i_W_dstE(W_dstE), .i_W_dstM(W_dstM), .i_W_valE(W_valE), .i_W_valM(W_valM),
        .o_d_srcA(d_srcA), .o_d_srcB(d_srcB),
        .o_E_stat(E_stat), .o_E_icode(E_icode), .o_E_ifun(E_ifun),
        .o_E_dstE(E_dstE), .o_E_dstM(E_dstM), .o_E_srcA(E_srcA), .o_E_srcB(E_srcB),
        .o_E_valC(E_valC), .o_E_valA(E_valA), .o_E_valB(E_valB),
        .o_load_use(load_use)
    );

    decode_stage #(.DATA_W(W), .NUM_REGS(8)) dut8 (
        .i_clk(clk), .i_reset(rst),
        .i_D_icode(D_icode), .i_D_ifun(D_ifun), .i_D_rA(D_rA), .i_D_rB(D_rB),
        .i_D_valC(D_valC), .i_D_valP(D_valP), .i_D_stat(D_stat),
        .i_E_stall(E_stall), .i_E_bubble(E_bubble),
        .i_e_dstE(e_dstE), .i_e_valE(e_valE),
        .i_M_dstE(M_dstE), .i_m_dstM(m_dstM), .i_M_valE(M_valE), .i_m_valM(m_valM),
        .i_W_dstE(W_dstE), .i_W_dstM(W_dstM), .i_W_valE(W_valE), .i_W_valM(W_valM),
        .o_d_srcA(d8_srcA), .o_d_srcB(d8_srcB),
        .o_E_stat(E8_stat), .o_E_icode(E8_icode), .o_E_ifun(E8_ifun),
        .o_E_dstE(E8_dstE), .o_E_dstM(E8_dstM), .o_E_srcA(E8_srcA), .o_E_srcB(E8_srcB),
        .o_E_valC(E8_valC), .o_E_valA(E8_valA), .o_E_valB(E8_valB),
        .o_load_use(load_use8)
    );

    // ------------------------------------------------------------------
    // checking helpers
    // ------------------------------------------------------------------
    int n_pass  = 0;
    int n_total = 0;
    int n_txn   = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ------------------------------------------------------------------
    // behavioural model of the 15-register instance
    // ------------------------------------------------------------------
    logic [W-1:0] m_regs [15];
    logic [2:0]   x_stat;
    logic [3:0]   x_icode, x_ifun, x_dstE, x_dstM, x_srcA, x_srcB;
    logic [W-1:0] x_valC, x_valA, x_valB;

    function automatic logic [3:0] f_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) return ra;
        if (ic inside {4'd9, 4'd11}) return 4'd4;
        return F;
    endfunction
    function automatic logic [3:0] f_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'd4, 4'd5, 4'd6}) return rb;
        if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
        return F;
    endfunction
    function automatic logic [3:0] f_dstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'd2, 4'd3, 4'd6}) return rb;
        if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'd4;
        return F;
    endfunction
    function automatic logic [3:0] f_dstM(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'd5, 4'd11}) return ra;
        return F;
    endfunction

    // value of a register as seen by decode right now: first matching
    // in-flight producer in age order, else the architectural value
    function automatic logic [W-1:0] f_operand(input logic [3:0] src);
        logic [3:0]   ids  [5];
        logic [W-1:0] vals [5];
        if (src == F) return '0;
        ids[0] = e_dstE; vals[0] = e_valE;
        ids[1] = m_dstM; vals[1] = m_valM;
        ids[2] = M_dstE; vals[2] = M_valE;
        ids[3] = W_dstM; vals[3] = W_valM;
        ids[4] = W_dstE; vals[4] = W_valE;
        for (int k = 0; k < 5; k++)
            if (ids[k] == src) return vals[k];
        return m_regs[src];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 15; i++) m_regs[i] <= '0;
            x_stat <= 3'd1; x_icode <= 4'd1; x_ifun <= 4'd0;
            x_dstE <= F; x_dstM <= F; x_srcA <= F; x_srcB <= F;
            x_valC <= '0; x_valA <= '0; x_valB <= '0;
        end else begin
            if (E_bubble) begin
                x_stat <= 3'd1; x_icode <= 4'd1; x_ifun <= 4'd0;
                x_dstE <= F; x_dstM <= F; x_srcA <= F; x_srcB <= F;
                x_valC <= '0; x_valA <= '0; x_valB <= '0;
            end else if (!E_stall) begin
                x_stat  <= D_stat;
                x_icode <= D_icode;
                x_ifun  <= D_ifun;
                x_dstE  <= f_dstE(D_icode, D_rB);
                x_dstM  <= f_dstM(D_icode, D_rA);
                x_srcA  <= f_srcA(D_icode, D_rA);
                x_srcB  <= f_srcB(D_icode, D_rB);
                x_valC  <= D_valC;
                x_valA  <= (D_icode inside {4'd7, 4'd8}) ? D_valP
                                                         : f_operand(f_srcA(D_icode, D_rA));
                x_valB  <= f_operand(f_srcB(D_icode, D_rB));
            end
            // later assignment wins: a load result overrides an ALU result
            if (W_dstE != F) m_regs[W_dstE] <= W_valE;
            if (W_dstM != F) m_regs[W_dstM] <= W_valM;
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] sa, sb;
            logic       lu;
            sa = f_srcA(D_icode, D_rA);
            sb = f_srcB(D_icode, D_rB);
            lu = (x_icode inside {4'd5, 4'd11}) && (x_dstM != F) &&
                 (x_dstM == sa || x_dstM == sb);
            check("d_srcA",   d_srcA,   sa);
            check("d_srcB",   d_srcB,   sb);
            check("load_use", load_use, lu);
            check("E_stat",   E_stat,   x_stat);
            check("E_icode",  E_icode,  x_icode);
            check("E_ifun",   E_ifun,   x_ifun);
            check("E_dstE",   E_dstE,   x_dstE);
            check("E_dstM",   E_dstM,   x_dstM);
            check("E_srcA",   E_srcA,   x_srcA);
            check("E_srcB",   E_srcB,   x_srcB);
            check("E_valC",   E_valC,   x_valC);
            check("E_valA",   E_valA,   x_valA);
            check("E_valB",   E_valB,   x_valB);
        end
    end

    // ------------------------------------------------------------------
    // stimulus helpers
    // ------------------------------------------------------------------
    task automatic idle();
        D_icode = 4'd1; D_ifun = 4'd0; D_rA = F; D_rB = F;
        D_valC = '0; D_valP = '0; D_stat = 3'd1;
        E_stall = 1'b0; E_bubble = 1'b0;
        e_dstE = F; M_dstE = F; m_dstM = F; W_dstE = F; W_dstM = F;
        e_valE = '0; M_valE = '0; m_valM = '0; W_valE = '0; W_valM = '0;
    endtask

    task automatic clear_fwd();
        e_dstE = F; M_dstE = F; m_dstM = F; W_dstE = F; W_dstM = F;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d: icode=%h rA=%h rB=%h -> E_icode=%h E_valA=%h E_valB=%h",
                 n_txn, D_icode, D_rA, D_rB, E_icode, E_valA, E_valB);
    endtask

    // ------------------------------------------------------------------
    // directed sequence
    // ------------------------------------------------------------------
    initial begin
        idle();
        #1 rst = 1'b1;
        #2;
        check("rst_E_icode", E_icode, 4'd1);
        check("rst_E_dstE",  E_dstE,  F);
        check("rst_E_stat",  E_stat,  3'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // fill every register; read it back in the same cycle through W forwarding
        for (int r = 0; r < 15; r++) begin
            W_dstE = 4'(r); W_valE = 64'h100 + 64'(r);
            D_icode = 4'd2; D_rA = 4'(r); D_rB = 4'd0;
            tick();
            if (r == 5) check("fill_fwd_r5", E_valA, 64'h105);
        end
        clear_fwd();
        D_icode = 4'd6; D_rA = 4'd9; D_rB = 4'd13;
        tick();
        check("array_r9",  E_valA, 64'h109);
        check("array_r13", E_valB, 64'h10D);
        check("opq_dstE",  E_dstE, 4'd13);

        // same-register double write: the load result wins
        idle();
        W_dstE = 4'd3; W_valE = 64'h11; W_dstM = 4'd3; W_valM = 64'h22;
        tick();
        clear_fwd();
        D_icode = 4'd2; D_rA = 4'd3; D_rB = 4'd5;
        tick();
        check("dual_write_valA", E_valA, 64'h22);

        // forwarding priority
        D_icode = 4'd6; D_rA = 4'd2; D_rB = 4'd1;
        e_dstE = 4'd2; e_valE = 64'hA;
        m_dstM = 4'd2; m_valM = 64'hB;
        W_dstE = 4'd2; W_valE = 64'hC;
        tick();
        check("fwd_e_first", E_valA, 64'hA);
        e_dstE = F;
        tick();
        check("fwd_m_second", E_valA, 64'hB);
        clear_fwd();
        D_icode = 4'd2; D_rA = 4'd2;
        tick();
        check("fwd_W_written", E_valA, 64'hC);

        // call: valA carries valP, stack pointer on B side
        D_icode = 4'd8; D_valP = 64'h40; D_rA = F; D_rB = F;
        tick();
        check("call_valA", E_valA, 64'h40);
        check("call_srcB", E_srcB, 4'd4);
        check("call_dstE", E_dstE, 4'd4);
        check("call_dstM", E_dstM, F);

        // load/use detection, then bubble beating stall
        D_icode = 4'd5; D_rA = 4'd6; D_rB = 4'd1; D_valC = 64'h8;
        tick();
        D_icode = 4'd6; D_rA = 4'd0; D_rB = 4'd6;
        #1;
        check("load_use_hit", load_use, 1'b1);
        D_rB = 4'd7;
        #1;
        check("load_use_miss", load_use, 1'b0);
        D_rB = 4'd6;
        E_stall = 1'b1; E_bubble = 1'b1;
        tick();
        check("bubble_wins", E_icode, 4'd1);
        check("bubble_dstM", E_dstM, F);
        E_stall = 1'b0; E_bubble = 1'b0;

        // stall holds E
        D_icode = 4'd2; D_rA = 4'd1; D_rB = 4'd2;
        tick();
        E_stall = 1'b1; D_icode = 4'd6;
        tick();
        check("stall_hold", E_icode, 4'd2);
        E_stall = 1'b0;

        // all sixteen icodes through the selector tables
        for (int ic = 0; ic < 16; ic++) begin
            D_icode = 4'(ic); D_ifun = 4'(ic ^ 5); D_rA = 4'd3; D_rB = 4'd7;
            D_valC = 64'hC0DE_0000 + 64'(ic); D_valP = 64'h2000 + 64'(ic);
            D_stat = (ic == 0) ? 3'd2 : 3'd1;
            tick();
            if (ic == 11) begin
                check("popq_srcA", E_srcA, 4'd4);
                check("popq_dstM", E_dstM, 4'd3);
            end
            if (ic == 12) check("ic12_dstE", E_dstE, F);
        end

        // asynchronous reset mid-run; a write pending during reset is dropped
        idle();
        W_dstE = 4'd3; W_valE = 64'h99;
        D_icode = 4'd6; D_rA = 4'd4; D_rB = 4'd5;
        tick();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_E_icode", E_icode, 4'd1);
        check("mid_rst_E_dstE",  E_dstE,  F);
        check("mid_rst_E_stat",  E_stat,  3'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        for (int r = 0; r < 15; r++) begin
            D_icode = 4'd2; D_rA = 4'(r); D_rB = 4'd0;
            tick();
            check("post_rst_read", E_valA, 64'h0);
        end

        // ID beyond NUM_REGS on the 8-register instance
        idle();
        W_dstE = 4'd10; W_valE = 64'h5;
        D_icode = 4'd2; D_rA = 4'd10; D_rB = 4'd0;
        tick();
        check("n8_id10_nofwd",  E8_valA, 64'h0);
        check("n15_id10_fwd",   E_valA,  64'h5);
        clear_fwd();
        tick();
        check("n8_id10_read",   E8_valA, 64'h0);
        check("n15_id10_read",  E_valA,  64'h5);
        W_dstE = 4'd7; W_valE = 64'h77;
        D_rA = 4'd7;
        tick();
        check("n8_id7_fwd", E8_valA, 64'h77);
        clear_fwd();
        tick();
        check("n8_id7_read", E8_valA, 64'h77);

        idle();
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
